// File: rtl/cla_pkg.sv
// Shared sizing constants, flag bundle and stage-count helper for the
// pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic int num_stages(input int width, input int groups_per_stage);
    return width / (GROUP_W * groups_per_stage);
  endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead slice: internal carries, group
// generate/propagate and carry-out are all flat sum-of-products terms.
module cla4_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               c,
  output logic [GROUP_W-1:0] s,
  output logic               g,
  output logic               p,
  output logic               c_out
);

  logic [GROUP_W-1:0] gen_s;
  logic [GROUP_W-1:0] prop_s;
  logic [GROUP_W:0]   carry_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  assign carry_s[0] = c;
  assign carry_s[1] = gen_s[0] | (prop_s[0] & c);
  assign carry_s[2] = gen_s[1] | (prop_s[1] & gen_s[0]) | (prop_s[1] & prop_s[0] & c);
  assign carry_s[3] = gen_s[2] | (prop_s[2] & gen_s[1]) | (prop_s[2] & prop_s[1] & gen_s[0])
                    | (prop_s[2] & prop_s[1] & prop_s[0] & c);

  assign g = gen_s[3] | (prop_s[3] & gen_s[2]) | (prop_s[3] & prop_s[2] & gen_s[1])
           | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0]);
  assign p = &prop_s;

  assign carry_s[4] = g | (p & c);
  assign c_out      = carry_s[4];
  assign s          = prop_s ^ carry_s[GROUP_W-1:0];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves GROUPS_PER_STAGE 4-bit groups and registers its carry.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGE_W    = GROUP_W * GROUPS_PER_STAGE;
  localparam int NUM_STAGES = num_stages(WIDTH, GROUPS_PER_STAGE);

  if ((WIDTH < STAGE_W) || ((WIDTH % STAGE_W) != 0)) begin : g_bad_params
    $error("cla_pipe_addsub: WIDTH must be a positive multiple of 4*GROUPS_PER_STAGE");
  end

  // Index 0 is the input register; index k is the output of stage k.
  logic [WIDTH-1:0] a_q     [0:NUM_STAGES];
  logic [WIDTH-1:0] b_q     [0:NUM_STAGES];
  logic [WIDTH-1:0] sum_q   [0:NUM_STAGES];
  logic             carry_q [0:NUM_STAGES];
  logic             valid_q [0:NUM_STAGES];
  flags_t           flags_q;

  logic             stall_s;
  logic             advance_s;
  logic [WIDTH-1:0] a0_r;
  logic [WIDTH-1:0] b0_r;
  logic             c0_r;
  logic             v0_r;

  assign stall_s   = valid_q[NUM_STAGES] & ~out_ready;
  assign advance_s = ~stall_s;
  assign in_ready  = advance_s;

  // Input register: subtraction is folded in as A + ~B + ~borrow_in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a0_r <= {WIDTH{1'b0}};
      b0_r <= {WIDTH{1'b0}};
      c0_r <= 1'b0;
      v0_r <= 1'b0;
    end else if (advance_s) begin
      a0_r <= a_in;
      b0_r <= sub ? ~b_in : b_in;
      c0_r <= c_in ^ sub;
      v0_r <= in_valid;
    end
  end

  assign a_q[0]     = a0_r;
  assign b_q[0]     = b0_r;
  assign sum_q[0]   = {WIDTH{1'b0}};
  assign carry_q[0] = c0_r;
  assign valid_q[0] = v0_r;

  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stage
    localparam int LO = (k - 1) * STAGE_W;

    logic [GROUPS_PER_STAGE-1:0] grp_g_s;
    logic [GROUPS_PER_STAGE-1:0] grp_p_s;
    logic [GROUPS_PER_STAGE-1:0] grp_co_s;
    logic [GROUPS_PER_STAGE:0]   grp_c_s;
    logic [STAGE_W-1:0]          slice_sum_s;
    logic [WIDTH-1:0]            sum_nxt_s;
    logic                        la_acc_s;
    logic                        la_prop_s;
    logic                        unused_grp_co_s;
    logic [WIDTH-1:0]            a_r;
    logic [WIDTH-1:0]            b_r;
    logic [WIDTH-1:0]            sum_r;
    logic                        carry_r;
    logic                        valid_r;

    for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_group
      cla4_group u_group (
        .a     (a_q[k-1][LO + j*GROUP_W +: GROUP_W]),
        .b     (b_q[k-1][LO + j*GROUP_W +: GROUP_W]),
        .c     (grp_c_s[j]),
        .s     (slice_sum_s[j*GROUP_W +: GROUP_W]),
        .g     (grp_g_s[j]),
        .p     (grp_p_s[j]),
        .c_out (grp_co_s[j])
      );
    end

    // Group carries come from the stage-level lookahead, not the ripple outputs.
    assign unused_grp_co_s = ^grp_co_s;

    // Stage lookahead: each group carry-in is an OR of G/P products plus the stage carry-in.
    always_comb begin
      grp_c_s    = {(GROUPS_PER_STAGE+1){1'b0}};
      la_acc_s   = 1'b0;
      la_prop_s  = 1'b1;
      grp_c_s[0] = carry_q[k-1];
      for (int j = 1; j <= GROUPS_PER_STAGE; j++) begin
        la_acc_s  = 1'b0;
        la_prop_s = 1'b1;
        for (int i = j - 1; i >= 0; i--) begin
          la_acc_s  = la_acc_s | (la_prop_s & grp_g_s[i]);
          la_prop_s = la_prop_s & grp_p_s[i];
        end
        grp_c_s[j] = la_acc_s | (la_prop_s & carry_q[k-1]);
      end
    end

    // Splice this stage's sum bits over the bits resolved by earlier stages.
    always_comb begin
      sum_nxt_s                = sum_q[k-1];
      sum_nxt_s[LO +: STAGE_W] = slice_sum_s;
    end

    // Stage register: operand skew, partial sum, outgoing carry and valid bit.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        a_r     <= {WIDTH{1'b0}};
        b_r     <= {WIDTH{1'b0}};
        sum_r   <= {WIDTH{1'b0}};
        carry_r <= 1'b0;
        valid_r <= 1'b0;
      end else if (advance_s) begin
        a_r     <= a_q[k-1];
        b_r     <= b_q[k-1];
        sum_r   <= sum_nxt_s;
        carry_r <= grp_c_s[GROUPS_PER_STAGE];
        valid_r <= valid_q[k-1];
      end
    end

    assign a_q[k]     = a_r;
    assign b_q[k]     = b_r;
    assign sum_q[k]   = sum_r;
    assign carry_q[k] = carry_r;
    assign valid_q[k] = valid_r;

    if (k == NUM_STAGES) begin : g_flags
      flags_t flags_nxt_s;
      flags_t flags_r;
      logic   msb_cin_s;

      // Carry into the MSB recovered from its sum bit and (effective) operand bits.
      assign msb_cin_s = a_q[k-1][WIDTH-1] ^ b_q[k-1][WIDTH-1] ^ sum_nxt_s[WIDTH-1];

      // Final flags from the completed sum.
      always_comb begin
        flags_nxt_s       = 3'b000;
        flags_nxt_s.c_out = grp_c_s[GROUPS_PER_STAGE];
        flags_nxt_s.ovf   = msb_cin_s ^ grp_c_s[GROUPS_PER_STAGE];
        flags_nxt_s.zero  = ~|sum_nxt_s;
      end

      // Flag register, aligned with the final sum register.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          flags_r <= 3'b000;
        end else if (advance_s) begin
          flags_r <= flags_nxt_s;
        end
      end

      assign flags_q = flags_r;
    end
  end

  assign out_valid = valid_q[NUM_STAGES];
  assign s_out     = sum_q[NUM_STAGES];
  assign c_out     = flags_q.c_out;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule
